// File: rtl/trig_id_capture.sv
// Trigger-ID receiver: deserialises an ID per trigger into a FWFT FIFO; `TRIG_ID_PARITY_EN adds an even-parity bit.
// Latency 2 edges from last strobe to rd_valid; no backpressure, a commit into a full FIFO sets overflow and drops.
module trig_id_capture #(
    parameter int ID_WIDTH   = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                          i_pll_clk,
    input  logic                          i_reset,
    input  logic                          i_trig_in_sync,
    input  logic                          i_trig_id_sync,
    input  logic                          i_bit_strobe,
    input  logic                          i_rd_en,
    input  logic                          i_clear_flags,
    output logic [ID_WIDTH-1:0]           o_rd_data,
    output logic                          o_rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
    output logic                          o_interrupt,
    output logic                          o_busy,
    output logic                          o_overflow,
    output logic                          o_timeout_err,
    output logic                          o_parity_err
);

`ifdef TRIG_ID_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int NBITS = ID_WIDTH + PAR_BITS;
    localparam int CW    = $clog2(NBITS + 1);
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNTW  = AW + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_COMMIT  = 2'd2;

    logic [1:0]          r_state;
    logic                r_trig_d;
    logic [NBITS-1:0]    r_shift;
    logic [CW-1:0]       r_bitcnt;
    logic [TW-1:0]       r_timer;
    logic [ID_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [CNTW-1:0]     r_count;
    logic                r_overflow;
    logic                r_timeout;

    logic                w_start;
    logic                w_strobe;
    logic                w_timeout;
    logic [ID_WIDTH-1:0] w_id;
    logic                w_par_ok;
    logic                w_full;
    logic                w_pop;
    logic                w_commit;
    logic                w_push;
    logic                w_drop;

    assign w_start   = i_trig_in_sync & ~r_trig_d;
    assign w_strobe  = (r_state == S_CAPTURE) & i_bit_strobe;
    assign w_timeout = (r_state == S_CAPTURE) & ~i_bit_strobe & (r_timer == TW'(TIMEOUT));

`ifdef TRIG_ID_PARITY_EN
    // Parity bit arrives last, so it sits in the LSB and is not stored.
    assign w_id     = r_shift[NBITS-1:1];
    assign w_par_ok = ~^r_shift;
`else
    assign w_id     = r_shift;
    assign w_par_ok = 1'b1;
`endif

    assign w_full   = (r_count == CNTW'(FIFO_DEPTH));
    assign w_pop    = i_rd_en & (r_count != '0);
    assign w_commit = (r_state == S_COMMIT) & w_par_ok;
    // A same-cycle pop frees the slot, so a full FIFO still accepts the write.
    assign w_push   = w_commit & (~w_full | w_pop);
    assign w_drop   = w_commit & w_full & ~w_pop;

    always_ff @(posedge i_pll_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state  <= S_IDLE;
            r_trig_d <= 1'b1;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_timer  <= '0;
        end else begin
            r_trig_d <= i_trig_in_sync;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state  <= S_CAPTURE;
                        r_shift  <= '0;
                        r_bitcnt <= '0;
                        r_timer  <= '0;
                    end
                end
                S_CAPTURE: begin
                    if (w_strobe) begin
                        r_shift  <= {r_shift[NBITS-2:0], i_trig_id_sync};
                        r_bitcnt <= r_bitcnt + CW'(1);
                        r_timer  <= '0;
                        if (r_bitcnt == CW'(NBITS - 1)) begin
                            r_state <= S_COMMIT;
                        end
                    end else if (w_timeout) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_COMMIT: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_pll_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_id;
        end
    end

    always_ff @(posedge i_pll_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky flags: a same-cycle raise beats clear_flags.
    always_ff @(posedge i_pll_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_overflow <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_overflow <= w_drop    | (r_overflow & ~i_clear_flags);
            r_timeout  <= w_timeout | (r_timeout  & ~i_clear_flags);
        end
    end

`ifdef TRIG_ID_PARITY_EN
    logic r_parity;
    always_ff @(posedge i_pll_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= ((r_state == S_COMMIT) & ~w_par_ok) | (r_parity & ~i_clear_flags);
        end
    end
    assign o_parity_err = r_parity;
`else
    assign o_parity_err = 1'b0;
`endif

    assign o_rd_valid    = (r_count != '0);
    assign o_rd_data     = o_rd_valid ? r_mem[r_rd_ptr] : '0;
    assign o_fifo_count  = r_count;
    assign o_interrupt   = ~o_rd_valid;
    assign o_busy        = (r_state == S_CAPTURE) | (r_state == S_COMMIT);
    assign o_overflow    = r_overflow;
    assign o_timeout_err = r_timeout;

endmodule

// File: tb/tb_trig_id_capture.sv
// Self-checking bench for trig_id_capture (ID_WIDTH=16, FIFO_DEPTH=8, TIMEOUT=255).
module tb_trig_id_capture;

    localparam int IDW   = 16;
    localparam int DEPTH = 8;
    localparam int TMO   = 255;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            trig = 1'b0;
    logic            tid = 1'b0;
    logic            strobe = 1'b0;
    logic            rd_en = 1'b0;
    logic            clr = 1'b0;
    logic [IDW-1:0]  rd_data;
    logic            rd_valid;
    logic [3:0]      fifo_count;
    logic            irq_n;
    logic            busy;
    logic            ovf;
    logic            tmo_err;
    logic            par_err;

    trig_id_capture #(.ID_WIDTH(IDW), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .i_pll_clk      (clk),
        .i_reset        (rst_n),
        .i_trig_in_sync (trig),
        .i_trig_id_sync (tid),
        .i_bit_strobe   (strobe),
        .i_rd_en        (rd_en),
        .i_clear_flags  (clr),
        .o_rd_data      (rd_data),
        .o_rd_valid     (rd_valid),
        .o_fifo_count   (fifo_count),
        .o_interrupt    (irq_n),
        .o_busy         (busy),
        .o_overflow     (ovf),
        .o_timeout_err  (tmo_err),
        .o_parity_err   (par_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [IDW-1:0] sb_q[$];
    bit m_ovf = 0;
    bit m_tmo = 0;
    bit m_par = 0;

    typedef struct {
        logic [IDW-1:0] id;
        int             exp_cnt;
        bit             exp_ovf;
    } vec_t;
    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rd_data"}, 32'(rd_data), 0);
        check({tag, "_rd_valid"}, 32'(rd_valid), 0);
        check({tag, "_count"}, 32'(fifo_count), 0);
        check({tag, "_irq_n"}, 32'(irq_n), 1);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_flags"}, {29'd0, ovf, tmo_err, par_err}, 0);
    endtask

    // One trigger plus all serial bits; gap_len idle cycles precede strobe gap_idx.
    task automatic capture(input logic [IDW-1:0] id, input bit pbit, input bit pop,
                           input int gap_idx, input int gap_len);
        int nb;
        bit ok;
        logic [IDW-1:0] head;
`ifdef TRIG_ID_PARITY_EN
        nb = IDW + 1;
        ok = ((^id) ^ pbit) == 1'b0;
`else
        nb = IDW;
        ok = 1'b1;
`endif
        trig = 1'b1;
        tick();
        trig = 1'b0;
        check("busy_after_start", 32'(busy), 1);
        for (int i = 0; i < nb; i++) begin
            if (i > 0) repeat ((i == gap_idx) ? gap_len : 1) tick();
            strobe = 1'b1;
            tid    = (i < IDW) ? id[IDW-1-i] : pbit;
            tick();
            strobe = 1'b0;
            tid    = 1'b0;
        end
        // COMMIT cycle: the write has not landed yet
        check("commit_count_pending", 32'(fifo_count), 32'(sb_q.size()));
        check("commit_busy", 32'(busy), 1);
        if (pop) begin
            rd_en = 1'b1;
            if (sb_q.size() > 0) begin
                head = sb_q.pop_front();
                check("pop_at_commit_head", 32'(rd_data), 32'(head));
            end
        end
        if (!ok) m_par = 1'b1;
        else if (sb_q.size() < DEPTH) sb_q.push_back(id);
        else m_ovf = 1'b1;
        tick();
        rd_en = 1'b0;
        check("post_count", 32'(fifo_count), 32'(sb_q.size()));
        check("post_overflow", 32'(ovf), 32'(m_ovf));
        check("post_parity", 32'(par_err), 32'(m_par));
        check("post_busy", 32'(busy), 0);
        check("post_irq_n", 32'(irq_n), (sb_q.size() == 0) ? 1 : 0);
    endtask

    task automatic pop_one();
        logic [IDW-1:0] exp;
        check("pop_valid", 32'(rd_valid), 1);
        exp = sb_q.pop_front();
        check("pop_data", 32'(rd_data), 32'(exp));
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("pop_count", 32'(fifo_count), 32'(sb_q.size()));
    endtask

    task automatic clear_all();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        m_ovf = 0; m_tmo = 0; m_par = 0;
        check("clear_flags", {29'd0, ovf, tmo_err, par_err}, 0);
    endtask

    initial begin
        for (int i = 0; i < 9; i++) begin
            vecs[i].id      = IDW'(i + 1);
            vecs[i].exp_cnt = (i < DEPTH) ? i + 1 : DEPTH;
            vecs[i].exp_ovf = (i >= DEPTH);
        end

        #3;
        check_reset_vals("reset");
        tick();
        rst_n = 1'b1;
        tick();

        // Single ID and pop back to empty
        capture(16'hA5C3, ^16'hA5C3, 1'b0, -1, 0);
        check("single_data", 32'(rd_data), 32'hA5C3);
        check("single_count", 32'(fifo_count), 1);
        check("single_irq", 32'(irq_n), 0);
        pop_one();
        check("empty_valid", 32'(rd_valid), 0);
        check("empty_irq", 32'(irq_n), 1);
        check("empty_data", 32'(rd_data), 0);

        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("underflow_count", 32'(fifo_count), 0);
        check("underflow_ovf", 32'(ovf), 0);

        // Fill and overflow from the vector table
        foreach (vecs[i]) begin
            capture(vecs[i].id, ^vecs[i].id, 1'b0, -1, 0);
            check("tbl_count", 32'(fifo_count), 32'(vecs[i].exp_cnt));
            check("tbl_overflow", 32'(ovf), 32'(vecs[i].exp_ovf));
        end
        repeat (DEPTH) pop_one();
        check("tbl_drained", 32'(rd_valid), 0);
        clear_all();

        // Push and pop in the same cycle at full
        for (int i = 1; i <= DEPTH; i++) capture(IDW'(i), ^(IDW'(i)), 1'b0, -1, 0);
        capture(16'd9, ^16'd9, 1'b1, -1, 0);
        check("full_pp_overflow", 32'(ovf), 0);
        check("full_pp_count", 32'(fifo_count), DEPTH);
        repeat (DEPTH) pop_one();

        // Timeout: 5 strobes then silence
        trig = 1'b1;
        tick();
        trig = 1'b0;
        for (int i = 0; i < 5; i++) begin
            strobe = 1'b1; tid = 1'b1;
            tick();
            strobe = 1'b0; tid = 1'b0;
        end
        repeat (TMO) tick();
        check("tmo_not_yet_busy", 32'(busy), 1);
        check("tmo_not_yet_flag", 32'(tmo_err), 0);
        tick();
        check("tmo_flag", 32'(tmo_err), 1);
        check("tmo_busy", 32'(busy), 0);
        check("tmo_count", 32'(fifo_count), 0);
        clear_all();

        // Strobe exactly when the timer hits TIMEOUT is accepted
        capture(16'h5A3C, ^16'h5A3C, 1'b0, 5, TMO);
        check("tmo_edge_flag", 32'(tmo_err), 0);
        pop_one();

`ifdef TRIG_ID_PARITY_EN
        capture(16'h0001, 1'b1, 1'b0, -1, 0);
        check("par_good_count", 32'(fifo_count), 1);
        capture(16'h0001, 1'b0, 1'b0, -1, 0);
        check("par_bad_flag", 32'(par_err), 1);
        check("par_bad_count", 32'(fifo_count), 1);
        clear_all();
        pop_one();
`endif

        // Reset mid-capture with 3 IDs stored and trigger held high
        for (int i = 0; i < 3; i++) capture(IDW'(16'h100 + i), ^(IDW'(16'h100 + i)), 1'b0, -1, 0);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        for (int i = 0; i < 7; i++) begin
            strobe = 1'b1; tid = 1'b1;
            tick();
            strobe = 1'b0; tid = 1'b0;
        end
        trig = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("async_reset");
        sb_q.delete();
        m_ovf = 0; m_tmo = 0; m_par = 0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            strobe = 1'b1;
            tick();
            strobe = 1'b0;
            check("held_trig_busy", 32'(busy), 0);
        end
        trig = 1'b0;
        tick();
        capture(16'h1234, ^16'h1234, 1'b0, -1, 0);
        pop_one();
        check("final_parity_flag", 32'(par_err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
